otter_csr_ext: RTL and testbench

Parametrised machine-mode CSR file, the next generation of the Otter CSR unit. It adds:
- a configurable number of platform (custom) interrupt lines mapped to mip/mie bits 16+;
- a standard-order interrupt priority encoder;
- 64-bit mcycle/minstret counters with mcountinhibit;
- a computed trap-target PC.

It sits beside the decoder and PC mux. The control FSM drives op_sel; the block returns read data, legality flags, an interrupt request and the trap/return PC.

---
 rtl/otter_csr_ext_pkg.sv | 75 +++++++
 rtl/otter_irq_prio.sv | 36 +++
 rtl/otter_csr_ext.sv | 176 +++++++++++++++++
 tb/tb_otter_csr_ext.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/otter_csr_ext_pkg.sv
// Shared constants for the Otter extended CSR file: op/funct3 encodings, CSR addresses,
// mcause codes and write masks. OTTER_CSR_VECTORED_EN enables mtvec vectored mode.
package otter_csr_ext_pkg;

  typedef enum logic [2:0] {
    CSR_OP_WRITE  = 3'd0,
    CSR_OP_ECALL  = 3'd1,
    CSR_OP_EBREAK = 3'd2,
    CSR_OP_MRET   = 3'd3,
    CSR_OP_INTRPT = 3'd4,
    CSR_OP_TRAP   = 3'd5,
    CSR_OP_WFI    = 3'd6,
    CSR_OP_NOP    = 3'd7
  } csr_op_e;

  typedef enum logic [1:0] {
    CSR_FUNCT3_LOW_NONE = 2'b00,
    CSR_FUNCT3_LOW_RW   = 2'b01,
    CSR_FUNCT3_LOW_RS   = 2'b10,
    CSR_FUNCT3_LOW_RC   = 2'b11
  } csr_funct3_low_e;

  localparam logic [11:0] CSR_MSTATUS_ADDR       = 12'h300;
  localparam logic [11:0] CSR_MIE_ADDR           = 12'h304;
  localparam logic [11:0] CSR_MTVEC_ADDR         = 12'h305;
  localparam logic [11:0] CSR_MCOUNTINHIBIT_ADDR = 12'h320;
  localparam logic [11:0] CSR_MSCRATCH_ADDR      = 12'h340;
  localparam logic [11:0] CSR_MEPC_ADDR          = 12'h341;
  localparam logic [11:0] CSR_MCAUSE_ADDR        = 12'h342;
  localparam logic [11:0] CSR_MTVAL_ADDR         = 12'h343;
  localparam logic [11:0] CSR_MIP_ADDR           = 12'h344;
  localparam logic [11:0] CSR_MCYCLE_ADDR        = 12'hB00;
  localparam logic [11:0] CSR_MINSTRET_ADDR      = 12'hB02;
  localparam logic [11:0] CSR_MCYCLEH_ADDR       = 12'hB80;
  localparam logic [11:0] CSR_MINSTRETH_ADDR     = 12'hB82;
  localparam logic [11:0] CSR_MVENDORID_ADDR     = 12'hF11;
  localparam logic [11:0] CSR_MARCHID_ADDR       = 12'hF12;
  localparam logic [11:0] CSR_MIMPID_ADDR        = 12'hF13;
  localparam logic [11:0] CSR_MHARTID_ADDR       = 12'hF14;

  localparam logic [4:0] MCAUSE_CODE_MSI        = 5'd3;
  localparam logic [4:0] MCAUSE_CODE_MTI        = 5'd7;
  localparam logic [4:0] MCAUSE_CODE_MEI        = 5'd11;
  localparam logic [4:0] MCAUSE_CODE_BREAKPOINT = 5'd3;
  localparam logic [4:0] MCAUSE_CODE_ECALL_M    = 5'd11;

  localparam logic [31:0] MSTATUS_FIXED       = 32'h0000_1800;
  localparam logic [31:0] MSTATUS_WMASK       = 32'h0000_0088;
  localparam logic [31:0] MIE_STD_MASK        = 32'h0000_0888;
  localparam logic [31:0] MEPC_WMASK          = 32'hFFFF_FFFC;
  localparam logic [31:0] MCAUSE_WMASK        = 32'h8000_001F;
  localparam logic [31:0] MCOUNTINHIBIT_WMASK = 32'h0000_0005;
`ifdef OTTER_CSR_VECTORED_EN
  localparam logic [31:0] MTVEC_WMASK         = 32'hFFFF_FFFD;
`else
  localparam logic [31:0] MTVEC_WMASK         = 32'hFFFF_FFFC;
`endif

  function automatic logic [31:0] custom_irq_mask(input int unsigned n);
    logic [31:0] m;
    m = '0;
    for (int unsigned i = 0; i < n; i++) m[16+i] = 1'b1;
    return m;
  endfunction

  function automatic logic [31:0] csr_wr_result(input logic [1:0] f3, input logic [31:0] cur,
                                                input logic [31:0] wd);
    case (f3)
      CSR_FUNCT3_LOW_RS: return cur | wd;
      CSR_FUNCT3_LOW_RC: return cur & ~wd;
      default:           return wd;
    endcase
  endfunction

endpackage

// File: rtl/otter_irq_prio.sv
// Standard-order interrupt priority encoder: MEI > MSI > MTI > custom (highest index first).
module otter_irq_prio
  import otter_csr_ext_pkg::*;
#(
  parameter int unsigned NUM_CUSTOM_IRQ = 4
) (
  input  logic [31:0] pending,
  output logic        valid,
  output logic [4:0]  code
);

  // Later assignments override earlier ones, so lowest priority is evaluated first.
  always_comb begin
    valid = 1'b0;
    code  = '0;
    for (int unsigned i = 0; i < NUM_CUSTOM_IRQ; i++) begin
      if (pending[16+i]) begin
        valid = 1'b1;
        code  = 5'(16 + i);
      end
    end
    if (pending[7]) begin
      valid = 1'b1;
      code  = MCAUSE_CODE_MTI;
    end
    if (pending[3]) begin
      valid = 1'b1;
      code  = MCAUSE_CODE_MSI;
    end
    if (pending[11]) begin
      valid = 1'b1;
      code  = MCAUSE_CODE_MEI;
    end
  end

endmodule

// File: rtl/otter_csr_ext.sv
// Machine-mode CSR file with platform IRQs, 64-bit counters and trap-target PC.
// Vectored mtvec mode is built only with OTTER_CSR_VECTORED_EN defined.
module otter_csr_ext
  import otter_csr_ext_pkg::*;
#(
  parameter int unsigned NUM_CUSTOM_IRQ = 4,
  parameter logic [31:0] MTVEC_RESET    = 32'h0000_0000,
  parameter bit          HAS_COUNTERS   = 1'b1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [16+NUM_CUSTOM_IRQ-1:0] irq_in,
  input  logic [2:0]                   op_sel,
  input  logic [4:0]                   trap_cause,
  input  logic [1:0]                   funct3_low,
  input  logic                         w_en,
  input  logic [11:0]                  addr,
  input  logic [31:0]                  w_data,
  input  logic [31:0]                  pc_addr,
  input  logic [31:0]                  mtval_in,
  input  logic                         instret,
  output logic [31:0]                  r_data,
  output logic                         addr_vld,
  output logic                         read_only,
  output logic                         intrpt_vld,
  output logic [31:0]                  trap_pc
);

  localparam logic [31:0] IRQ_MASK = MIE_STD_MASK | custom_irq_mask(NUM_CUSTOM_IRQ);

  csr_op_e     op;
  logic        st_mie, st_mpie;
  logic [31:0] mie_q, mip_q, mtvec_q, mscratch_q, mepc_q, mcause_q, mtval_q, minhibit_q;
  logic [63:0] mcycle_q, minstret_q;
  logic [31:0] mstatus_rd, mtvec_base, wr_val;
  logic        wr_en, trap_entry, irq_valid;
  logic [4:0]  irq_code;

  assign op         = csr_op_e'(op_sel);
  assign mstatus_rd = MSTATUS_FIXED | {24'b0, st_mpie, 3'b0, st_mie, 3'b0};
  assign mtvec_base = {mtvec_q[31:2], 2'b00};
  assign read_only  = (addr[11:10] == 2'b11);
  assign wr_val     = csr_wr_result(funct3_low, r_data, w_data);
  assign wr_en      = (op == CSR_OP_WRITE) && w_en && addr_vld && !read_only
                      && (funct3_low != CSR_FUNCT3_LOW_NONE);
  assign trap_entry = op inside {CSR_OP_ECALL, CSR_OP_EBREAK, CSR_OP_TRAP, CSR_OP_INTRPT};

  otter_irq_prio #(.NUM_CUSTOM_IRQ(NUM_CUSTOM_IRQ)) u_prio (
    .pending (mie_q & mip_q),
    .valid   (irq_valid),
    .code    (irq_code)
  );

  assign intrpt_vld = irq_valid && st_mie;

  always_comb begin
    trap_pc = mtvec_base;
    if (op == CSR_OP_MRET) trap_pc = mepc_q;
`ifdef OTTER_CSR_VECTORED_EN
    else if (op == CSR_OP_INTRPT && mtvec_q[0]) trap_pc = mtvec_base + {25'b0, irq_code, 2'b00};
`endif
  end

  always_comb begin
    r_data   = '0;
    addr_vld = 1'b1;
    case (addr)
      CSR_MSTATUS_ADDR:       r_data = mstatus_rd;
      CSR_MIE_ADDR:           r_data = mie_q;
      CSR_MTVEC_ADDR:         r_data = mtvec_q;
      CSR_MSCRATCH_ADDR:      r_data = mscratch_q;
      CSR_MEPC_ADDR:          r_data = mepc_q;
      CSR_MCAUSE_ADDR:        r_data = mcause_q;
      CSR_MTVAL_ADDR:         r_data = mtval_q;
      CSR_MIP_ADDR:           r_data = mip_q;
      CSR_MVENDORID_ADDR, CSR_MARCHID_ADDR,
      CSR_MIMPID_ADDR, CSR_MHARTID_ADDR: r_data = '0;
      CSR_MCYCLE_ADDR: begin
        addr_vld = HAS_COUNTERS;
        r_data   = HAS_COUNTERS ? mcycle_q[31:0] : '0;
      end
      CSR_MCYCLEH_ADDR: begin
        addr_vld = HAS_COUNTERS;
        r_data   = HAS_COUNTERS ? mcycle_q[63:32] : '0;
      end
      CSR_MINSTRET_ADDR: begin
        addr_vld = HAS_COUNTERS;
        r_data   = HAS_COUNTERS ? minstret_q[31:0] : '0;
      end
      CSR_MINSTRETH_ADDR: begin
        addr_vld = HAS_COUNTERS;
        r_data   = HAS_COUNTERS ? minstret_q[63:32] : '0;
      end
      CSR_MCOUNTINHIBIT_ADDR: begin
        addr_vld = HAS_COUNTERS;
        r_data   = HAS_COUNTERS ? minhibit_q : '0;
      end
      default: addr_vld = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_mie     <= 1'b0;
      st_mpie    <= 1'b0;
      mie_q      <= '0;
      mip_q      <= '0;
      mtvec_q    <= MTVEC_RESET & 32'hFFFF_FFFC;
      mscratch_q <= '0;
      mepc_q     <= '0;
      mcause_q   <= '0;
      mtval_q    <= '0;
    end else begin
      mip_q <= 32'(irq_in) & IRQ_MASK;
      if (wr_en) begin
        case (addr)
          CSR_MSTATUS_ADDR: begin
            st_mie  <= wr_val[3];
            st_mpie <= wr_val[7];
          end
          CSR_MIE_ADDR:      mie_q      <= wr_val & IRQ_MASK;
          CSR_MTVEC_ADDR:    mtvec_q    <= wr_val & MTVEC_WMASK;
          CSR_MSCRATCH_ADDR: mscratch_q <= wr_val;
          CSR_MEPC_ADDR:     mepc_q     <= wr_val & MEPC_WMASK;
          CSR_MCAUSE_ADDR:   mcause_q   <= wr_val & MCAUSE_WMASK;
          CSR_MTVAL_ADDR:    mtval_q    <= wr_val;
          default: ;
        endcase
      end
      if (trap_entry) begin
        mepc_q  <= pc_addr;
        st_mpie <= st_mie;
        st_mie  <= 1'b0;
        case (op)
          CSR_OP_ECALL: begin
            mcause_q <= {27'b0, MCAUSE_CODE_ECALL_M};
            mtval_q  <= '0;
          end
          CSR_OP_EBREAK: begin
            mcause_q <= {27'b0, MCAUSE_CODE_BREAKPOINT};
            mtval_q  <= mtval_in;
          end
          CSR_OP_TRAP: begin
            mcause_q <= {27'b0, trap_cause};
            mtval_q  <= mtval_in;
          end
          default: begin
            if (irq_valid) mcause_q <= {1'b1, 26'b0, irq_code};
            mtval_q <= '0;
          end
        endcase
      end else if (op == CSR_OP_MRET) begin
        st_mie  <= st_mpie;
        st_mpie <= 1'b1;
      end
    end
  end

  // A write to either half suppresses the whole 64-bit increment for that cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcycle_q   <= '0;
      minstret_q <= '0;
      minhibit_q <= '0;
    end else if (HAS_COUNTERS) begin
      if (wr_en && addr == CSR_MCOUNTINHIBIT_ADDR) minhibit_q <= wr_val & MCOUNTINHIBIT_WMASK;
      if (wr_en && addr == CSR_MCYCLE_ADDR)        mcycle_q[31:0]  <= wr_val;
      else if (wr_en && addr == CSR_MCYCLEH_ADDR)  mcycle_q[63:32] <= wr_val;
      else if (!minhibit_q[0])                     mcycle_q <= mcycle_q + 64'd1;
      if (wr_en && addr == CSR_MINSTRET_ADDR)       minstret_q[31:0]  <= wr_val;
      else if (wr_en && addr == CSR_MINSTRETH_ADDR) minstret_q[63:32] <= wr_val;
      else if (instret && !minhibit_q[2])           minstret_q <= minstret_q + 64'd1;
    end
  end

endmodule

// File: tb/tb_otter_csr_ext.sv
// Randomized self-checking bench for otter_csr_ext against a behavioural CSR model,
// preceded by directed reset / interrupt / counter / read-only / mtvec scenarios.
module tb_otter_csr_ext;
  import otter_csr_ext_pkg::*;

  localparam int unsigned NCUST = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [19:0] irq_in = '0;
  logic [2:0]  op_sel = CSR_OP_NOP;
  logic [4:0]  trap_cause = '0;
  logic [1:0]  funct3_low = '0;
  logic        w_en = 1'b0;
  logic [11:0] addr = '0;
  logic [31:0] w_data = '0, pc_addr = '0, mtval_in = '0;
  logic        instret = 1'b0;
  logic [31:0] r_data, trap_pc;
  logic        addr_vld, read_only, intrpt_vld;

  otter_csr_ext #(.NUM_CUSTOM_IRQ(NCUST), .MTVEC_RESET(32'h0000_0203), .HAS_COUNTERS(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .irq_in(irq_in), .op_sel(op_sel), .trap_cause(trap_cause),
    .funct3_low(funct3_low), .w_en(w_en), .addr(addr), .w_data(w_data), .pc_addr(pc_addr),
    .mtval_in(mtval_in), .instret(instret), .r_data(r_data), .addr_vld(addr_vld),
    .read_only(read_only), .intrpt_vld(intrpt_vld), .trap_pc(trap_pc)
  );

  always #5 clk = ~clk;

  int unsigned n_checks = 0, n_fail = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model state
  bit              m_mie, m_mpie;
  logic [31:0]     m_ie, m_ip, m_tvec, m_scratch, m_epc, m_cause, m_tval, m_inh;
  longint unsigned m_cyc, m_ins;
  localparam logic [31:0] M_IRQ_MASK = 32'h000F_0888;
`ifdef OTTER_CSR_VECTORED_EN
  localparam bit VEC = 1'b1;
`else
  localparam bit VEC = 1'b0;
`endif

  task automatic m_reset();
    m_mie = 0; m_mpie = 0; m_ie = 0; m_ip = 0; m_tvec = 32'h200; m_scratch = 0;
    m_epc = 0; m_cause = 0; m_tval = 0; m_inh = 0; m_cyc = 0; m_ins = 0;
  endtask

  function automatic logic [31:0] m_read(input logic [11:0] a, output bit vld);
    vld = 1;
    case (a)
      12'h300: return 32'h1800 | (32'(m_mpie) << 7) | (32'(m_mie) << 3);
      12'h304: return m_ie;
      12'h305: return m_tvec;
      12'h340: return m_scratch;
      12'h341: return m_epc;
      12'h342: return m_cause;
      12'h343: return m_tval;
      12'h344: return m_ip;
      12'hF11, 12'hF12, 12'hF13, 12'hF14: return 0;
      12'hB00: return m_cyc[31:0];
      12'hB80: return m_cyc[63:32];
      12'hB02: return m_ins[31:0];
      12'hB82: return m_ins[63:32];
      12'h320: return m_inh;
      default: begin vld = 0; return 0; end
    endcase
  endfunction

  // Highest-priority pending enabled interrupt, or -1.
  function automatic int m_prio();
    logic [31:0] p = m_ie & m_ip;
    if (p[11]) return 11;
    if (p[3])  return 3;
    if (p[7])  return 7;
    for (int i = 31; i >= 16; i--) if (p[i]) return i;
    return -1;
  endfunction

  task automatic m_update(input logic [2:0] op, input logic [1:0] f3, input logic we,
                          input logic [11:0] a, input logic [31:0] wd);
    bit vld, cyc_w, ins_w;
    logic [31:0] cur, wv, old_inh;
    int code;
    cur = m_read(a, vld);
    code = m_prio();
    old_inh = m_inh;
    cyc_w = 0; ins_w = 0;
    wv = (f3 == 2'b10) ? (cur | wd) : (f3 == 2'b11) ? (cur & ~wd) : wd;
    if (op == CSR_OP_WRITE && we && vld && a[11:10] != 2'b11 && f3 != 2'b00) begin
      case (a)
        12'h300: begin m_mie = wv[3]; m_mpie = wv[7]; end
        12'h304: m_ie = wv & M_IRQ_MASK;
        12'h305: m_tvec = wv & (VEC ? 32'hFFFF_FFFD : 32'hFFFF_FFFC);
        12'h340: m_scratch = wv;
        12'h341: m_epc = wv & 32'hFFFF_FFFC;
        12'h342: m_cause = wv & 32'h8000_001F;
        12'h343: m_tval = wv;
        12'hB00: begin m_cyc = {m_cyc[63:32], wv}; cyc_w = 1; end
        12'hB80: begin m_cyc = {wv, m_cyc[31:0]}; cyc_w = 1; end
        12'hB02: begin m_ins = {m_ins[63:32], wv}; ins_w = 1; end
        12'hB82: begin m_ins = {wv, m_ins[31:0]}; ins_w = 1; end
        12'h320: m_inh = wv & 32'h5;
        default: ;
      endcase
    end
    if (!cyc_w && !old_inh[0]) m_cyc = m_cyc + 1;
    if (!ins_w && instret && !old_inh[2]) m_ins = m_ins + 1;
    if (op inside {CSR_OP_ECALL, CSR_OP_EBREAK, CSR_OP_TRAP, CSR_OP_INTRPT}) begin
      m_epc = pc_addr; m_mpie = m_mie; m_mie = 0;
      case (op)
        CSR_OP_ECALL:  begin m_cause = 11; m_tval = 0; end
        CSR_OP_EBREAK: begin m_cause = 3; m_tval = mtval_in; end
        CSR_OP_TRAP:   begin m_cause = 32'(trap_cause); m_tval = mtval_in; end
        default: begin
          if (code >= 0) m_cause = 32'h8000_0000 + 32'(code);
          m_tval = 0;
        end
      endcase
    end else if (op == CSR_OP_MRET) begin
      m_mie = m_mpie; m_mpie = 1;
    end
    m_ip = 32'(irq_in) & M_IRQ_MASK;
  endtask

  logic [19:0] s_irq = '0;
  logic [31:0] s_pc = 32'h0000_4000;
  logic [31:0] obs_rd, obs_tpc;
  logic        obs_ro, obs_iv;

  // One clock: drive, compare all outputs at negedge, then advance the model at posedge.
  task automatic step(input logic [2:0] op, input logic [1:0] f3, input logic we,
                      input logic [11:0] a, input logic [31:0] wd);
    bit vld;
    logic [31:0] exp_rd, base, exp_pc;
    int code;
    op_sel = op; funct3_low = f3; w_en = we; addr = a; w_data = wd;
    irq_in = s_irq; pc_addr = s_pc;
    @(negedge clk);
    exp_rd = m_read(a, vld);
    code = m_prio();
    base = m_tvec & 32'hFFFF_FFFC;
    exp_pc = (op == CSR_OP_MRET) ? m_epc : base;
    if (VEC && op == CSR_OP_INTRPT && m_tvec[0] && code >= 0) exp_pc = base + 32'(4 * code);
    check_eq("r_data", r_data, exp_rd);
    check_eq("addr_vld", 32'(addr_vld), 32'(vld));
    check_eq("read_only", 32'(read_only), 32'(a[11:10] == 2'b11));
    check_eq("intrpt_vld", 32'(intrpt_vld), 32'(code >= 0 && m_mie));
    check_eq("trap_pc", trap_pc, exp_pc);
    obs_rd = r_data; obs_tpc = trap_pc; obs_ro = read_only; obs_iv = intrpt_vld;
    @(posedge clk);
    if (rst_n) m_update(op, f3, we, a, wd); else m_reset();
    #1;
  endtask

  localparam logic [2:0] W = CSR_OP_WRITE, N = CSR_OP_NOP;
  logic [11:0] addr_tab [0:19] = '{12'h300, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342,
    12'h343, 12'h344, 12'hF11, 12'hF14, 12'hB00, 12'hB80, 12'hB02, 12'hB82, 12'h320,
    12'h320, 12'h7C0, 12'h345, 12'hC00, 12'h301};

  initial begin
    m_reset();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Reset mid-run
    step(W, 2'b01, 1, 12'hB00, 32'h1234);
    step(N, 2'b01, 0, 12'hB00, 0);
    check_eq("mcycle_pre_reset", obs_rd, 32'h1234);
    step(W, 2'b01, 1, 12'h340, 32'hDEAD_BEEF);
    rst_n = 1'b0; m_reset();
    step(N, 2'b01, 0, 12'h300, 0); check_eq("rst_mstatus", obs_rd, 32'h0000_1800);
    step(N, 2'b01, 0, 12'hB00, 0); check_eq("rst_mcycle", obs_rd, 32'h0);
    step(N, 2'b01, 0, 12'h340, 0); check_eq("rst_mscratch", obs_rd, 32'h0);
    step(N, 2'b01, 0, 12'h305, 0); check_eq("rst_mtvec", obs_rd, 32'h200);
    check_eq("rst_trap_pc", obs_tpc, 32'h200);
    check_eq("rst_intrpt_vld", 32'(obs_iv), 0);
    rst_n = 1'b1;

    // Interrupt latency and MTI-over-custom priority
    step(W, 2'b01, 1, 12'h304, 32'h0001_0888);
    step(W, 2'b01, 1, 12'h300, 32'h8);
    s_irq = 20'h1_0080;
    step(N, 2'b01, 0, 12'h344, 0); check_eq("ivld_before_sample", 32'(obs_iv), 0);
    step(N, 2'b01, 0, 12'h344, 0); check_eq("ivld_after_sample", 32'(obs_iv), 1);
    step(CSR_OP_INTRPT, 2'b01, 0, 12'h342, 0);
    step(N, 2'b01, 0, 12'h342, 0); check_eq("mcause_mti", obs_rd, 32'h8000_0007);
    step(N, 2'b01, 0, 12'h300, 0); check_eq("mstatus_after_int", obs_rd, 32'h0000_1880);

    // MEI wins over everything, then MRET
    s_irq = 20'h1_0888; s_pc = 32'h0000_5000;
    step(W, 2'b01, 1, 12'h300, 32'h8);
    step(CSR_OP_INTRPT, 2'b01, 0, 12'h342, 0);
    step(N, 2'b01, 0, 12'h342, 0); check_eq("mcause_mei", obs_rd, 32'h8000_000B);
    step(CSR_OP_MRET, 2'b01, 0, 12'h300, 0); check_eq("mret_trap_pc", obs_tpc, 32'h0000_5000);
    step(N, 2'b01, 0, 12'h300, 0); check_eq("mstatus_after_mret", obs_rd, 32'h0000_1888);
    s_irq = '0;
    step(W, 2'b01, 1, 12'h300, 32'h0);

    // 64-bit carry and write-wins
    step(W, 2'b01, 1, 12'hB00, 32'hFFFF_FFFF);
    step(W, 2'b01, 1, 12'hB80, 32'h0);
    step(N, 2'b01, 0, 12'hB80, 0);
    step(N, 2'b01, 0, 12'hB00, 0); check_eq("mcycle_wrap_lo", obs_rd, 32'h0);
    step(N, 2'b01, 0, 12'hB80, 0); check_eq("mcycle_carry_hi", obs_rd, 32'h1);
    step(W, 2'b01, 1, 12'hB80, 32'h0);
    step(W, 2'b01, 1, 12'hB00, 32'hFFFF_FFFF);
    step(W, 2'b10, 1, 12'hB80, 32'h10);
    step(N, 2'b01, 0, 12'hB80, 0); check_eq("mcycleh_write_wins", obs_rd, 32'h10);

    // Read-only and CSRRC
    step(W, 2'b01, 1, 12'hF11, 32'hFFFF); check_eq("mvendorid_ro", 32'(obs_ro), 1);
    step(N, 2'b01, 0, 12'hF11, 0); check_eq("mvendorid_val", obs_rd, 32'h0);
    step(W, 2'b01, 1, 12'h304, 32'h888);
    step(W, 2'b11, 1, 12'h304, 32'h8);
    step(N, 2'b01, 0, 12'h304, 0); check_eq("mie_csrrc", obs_rd, 32'h880);

    // mtvec mode bit and trap target
    step(W, 2'b01, 1, 12'h305, 32'h1001);
    step(N, 2'b01, 0, 12'h305, 0); check_eq("mtvec_mode", obs_rd, VEC ? 32'h1001 : 32'h1000);
    s_irq = 20'h0_0800;
    step(W, 2'b01, 1, 12'h300, 32'h8);
    step(CSR_OP_INTRPT, 2'b01, 0, 12'h305, 0);
    check_eq("mei_trap_pc", obs_tpc, VEC ? 32'h102C : 32'h1000);

    // Randomized phase
    for (int k = 0; k < 2000; k++) begin
      int unsigned r;
      logic [2:0] op;
      logic [31:0] wd;
      r = $urandom_range(0, 11);
      op = (r < 5) ? CSR_OP_WRITE : (r == 5) ? CSR_OP_NOP : (r == 6) ? CSR_OP_WFI :
           (r == 7) ? CSR_OP_ECALL : (r == 8) ? CSR_OP_EBREAK : (r == 9) ? CSR_OP_TRAP :
           (r == 10) ? CSR_OP_INTRPT : CSR_OP_MRET;
      if ($urandom_range(0, 7) == 0) s_irq = 20'($urandom);
      s_pc = $urandom;
      mtval_in = $urandom;
      trap_cause = 5'($urandom);
      instret = 1'($urandom);
      wd = ($urandom_range(0, 5) == 0) ? 32'hFFFF_FFFF : $urandom;
      step(op, 2'($urandom), 1'($urandom_range(0, 3) != 0),
           addr_tab[$urandom_range(0, 19)], wd);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
